// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - USB full-speed TX encoder: SYNC, bit stuffing, NRZI, EOP toward the pads.
// Optional abort (7 unstuffed ones, then EOP) is built when USB_TX_ABORT_EN is defined.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
`ifdef USB_TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, EOP_SE0, EOP_J
`ifdef USB_TX_ABORT_EN
    , ABORT
`endif
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    sh;
  logic [3:0]    nbits;
  logic [2:0]    ones;
  logic          level;
  logic          last_byte;
  logic          stuffing;
  logic          end_pending;
  logic          eop_cnt;

  logic in_pkt, boundary, abort_now, byte_end, fetch, underrun;
  logic go_eop, take_data, tx_bit, next_level;

  assign in_pkt   = (state == SYNC) || (state == DATA);
  assign boundary = (state != IDLE) && (timer == T_MAX);

`ifdef USB_TX_ABORT_EN
  logic       abort_req;
  logic [2:0] abort_cnt;
  assign abort_now = in_pkt && (abort_req || tx_abort);
`else
  assign abort_now = 1'b0;
`endif

  // SYNC is handled as a pre-loaded byte, so its last bit ending is also a fetch point.
  assign byte_end = boundary && in_pkt && (nbits == 4'd0) && !stuffing;
  assign fetch    = byte_end && !last_byte && !abort_now;
  // Ready is combinational so the handshake completes on the same edge that loads the byte.
  assign tx_ready = fetch && tx_valid;
  assign underrun = fetch && !tx_valid;

  always_comb begin
    go_eop    = 1'b0;
    take_data = 1'b0;
    tx_bit    = 1'b0;
    if (ones == 3'd6) begin
      tx_bit = 1'b0;
    end else if (end_pending || underrun || (byte_end && last_byte)) begin
      go_eop = 1'b1;
    end else begin
      take_data = 1'b1;
      tx_bit    = tx_ready ? tx_data[0] : sh[0];
    end
    next_level = tx_bit ? level : ~level;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      timer       <= '0;
      sh          <= '0;
      nbits       <= '0;
      ones        <= '0;
      level       <= 1'b1;
      last_byte   <= 1'b0;
      stuffing    <= 1'b0;
      end_pending <= 1'b0;
      eop_cnt     <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      d_plus      <= 1'b1;
      d_minus     <= 1'b0;
`ifdef USB_TX_ABORT_EN
      abort_req   <= 1'b0;
      abort_cnt   <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (state == IDLE)
        timer <= '0;
      else
        timer <= boundary ? '0 : timer + TW'(1);

      case (state)
        IDLE: begin
          if (tx_valid) begin
            // First SYNC bit (a 0) goes out immediately; the remaining seven stay queued.
            state       <= SYNC;
            tx_busy     <= 1'b1;
            level       <= 1'b0;
            d_plus      <= 1'b0;
            d_minus     <= 1'b1;
            sh          <= 8'h40;
            nbits       <= 4'd7;
            ones        <= '0;
            last_byte   <= 1'b0;
            stuffing    <= 1'b0;
            end_pending <= 1'b0;
            eop_cnt     <= 1'b0;
`ifdef USB_TX_ABORT_EN
            abort_req   <= 1'b0;
            abort_cnt   <= '0;
`endif
          end
        end

        SYNC, DATA: begin
`ifdef USB_TX_ABORT_EN
          if (!boundary && tx_abort)
            abort_req <= 1'b1;
`endif
          if (boundary) begin
`ifdef USB_TX_ABORT_EN
            if (abort_now) begin
              state     <= ABORT;
              abort_cnt <= 3'd1;
              abort_req <= 1'b0;
            end else
`endif
            begin
              if (tx_ready) begin
                state     <= DATA;
                last_byte <= tx_last;
              end
              if (underrun)
                tx_error <= 1'b1;
              if (go_eop) begin
                state   <= EOP_SE0;
                eop_cnt <= 1'b0;
                d_plus  <= 1'b0;
                d_minus <= 1'b0;
              end else begin
                level    <= next_level;
                d_plus   <= next_level;
                d_minus  <= ~next_level;
                ones     <= tx_bit ? ones + 3'd1 : 3'd0;
                stuffing <= !take_data;
                if (!take_data && (underrun || (byte_end && last_byte)))
                  end_pending <= 1'b1;
                if (tx_ready) begin
                  sh    <= take_data ? {1'b0, tx_data[7:1]} : tx_data;
                  nbits <= take_data ? 4'd7 : 4'd8;
                end else if (take_data) begin
                  sh    <= {1'b0, sh[7:1]};
                  nbits <= nbits - 4'd1;
                end
              end
            end
          end
        end

`ifdef USB_TX_ABORT_EN
        ABORT: begin
          // Line is simply held: seven unstuffed ones under NRZI.
          if (boundary) begin
            if (abort_cnt == 3'd7) begin
              state   <= EOP_SE0;
              eop_cnt <= 1'b0;
              d_plus  <= 1'b0;
              d_minus <= 1'b0;
            end else begin
              abort_cnt <= abort_cnt + 3'd1;
            end
          end
        end
`endif

        EOP_SE0: begin
          if (boundary) begin
            if (eop_cnt) begin
              state   <= EOP_J;
              d_plus  <= 1'b1;
              d_minus <= 1'b0;
            end else begin
              eop_cnt <= 1'b1;
            end
          end
        end

        EOP_J: begin
          if (boundary) begin
            state   <= IDLE;
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            level   <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
